// File: rtl/piso_shift_reg_if.sv
// Word/serial handshake bundle for the PISO shift register.
// Controller side is the master; the shift register is the slave.
interface piso_shift_reg_if #(
    parameter int WIDTH = 4
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] P;
    logic             LD;
    logic             EN;
    logic             Q;
    logic             BUSY;
    logic             DONE;
    logic [CW-1:0]    CNT;

    modport master (
        output P, LD, EN,
        input  Q, BUSY, DONE, CNT
    );

    modport slave (
        input  P, LD, EN,
        output Q, BUSY, DONE, CNT
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: captures a word on LD and shifts it
// out MSB-first, one bit per enabled clock, with BUSY/DONE pacing.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input logic            C,
    input logic            R,
    piso_shift_reg_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;

    // Word sequencer: load, shift with stall, one-cycle FIN for back-to-back pacing.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_r <= IDLE;
            sreg_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.LD) begin
                        state_r <= SHIFT;
                        sreg_r  <= bus.P;
                        cnt_r   <= CW'(WIDTH - 1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.EN) begin
                        if (cnt_r != {CW{1'b0}}) begin
                            sreg_r <= sreg_r << 1;
                            cnt_r  <= cnt_r - CW'(1);
                        end else begin
                            // Last bit has had its cycle; clear so Q idles low in FIN.
                            sreg_r  <= {WIDTH{1'b0}};
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= FIN;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                FIN: begin
                    done_r <= 1'b0;
                    if (bus.LD) begin
                        state_r <= SHIFT;
                        sreg_r  <= bus.P;
                        cnt_r   <= CW'(WIDTH - 1);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sreg_r  <= {WIDTH{1'b0}};
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q    = sreg_r[WIDTH-1];
    assign bus.CNT  = cnt_r;
    assign bus.BUSY = busy_r;
    assign bus.DONE = done_r;
endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (WIDTH=4): reset, basic word, stall,
// LD-while-busy, back-to-back words and asynchronous reset mid-word.
module tb_piso_shift_reg;
    logic C;
    logic R;
    int   n_checks;
    int   n_fail;

    piso_shift_reg_if #(.WIDTH(4)) bus_if ();

    piso_shift_reg #(.WIDTH(4)) dut (
        .C   (C),
        .R   (R),
        .bus (bus_if)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        bus_if.LD = 1'b0;
        bus_if.EN = 1'b1;
        bus_if.P  = 4'b1111;
        #12;
        R = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (bus_if.Q !== 1'b0) begin
                n_fail++; $display("FAIL reset_q edge%0d: got %b want 0", k, bus_if.Q);
            end
            n_checks++;
            if (bus_if.BUSY !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy edge%0d: got %b want 0", k, bus_if.BUSY);
            end
            n_checks++;
            if (bus_if.DONE !== 1'b0) begin
                n_fail++; $display("FAIL reset_done edge%0d: got %b want 0", k, bus_if.DONE);
            end
            n_checks++;
            if (bus_if.CNT !== 2'd0) begin
                n_fail++; $display("FAIL reset_cnt edge%0d: got %0d want 0", k, bus_if.CNT);
            end
        end
    endtask

    task automatic test_basic_word(input bit ld_mid);
        int exp_q[6]    = '{1, 0, 1, 1, 0, 0};
        int exp_cnt[6]  = '{3, 2, 1, 0, 0, 0};
        int exp_busy[6] = '{1, 1, 1, 1, 0, 0};
        int exp_done[6] = '{0, 0, 0, 0, 1, 0};
        bus_if.P  = 4'b1011;
        bus_if.LD = 1'b1;
        bus_if.EN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            bus_if.LD = (ld_mid && k == 1) ? 1'b1 : 1'b0;
            bus_if.P  = (ld_mid && k == 1) ? 4'b0110 : 4'b1011;
            n_checks++;
            if (bus_if.Q !== 1'(exp_q[k])) begin
                n_fail++; $display("FAIL basic_q ld_mid=%0d edge%0d: got %b want %0d", ld_mid, k, bus_if.Q, exp_q[k]);
            end
            n_checks++;
            if (bus_if.CNT !== 2'(exp_cnt[k])) begin
                n_fail++; $display("FAIL basic_cnt ld_mid=%0d edge%0d: got %0d want %0d", ld_mid, k, bus_if.CNT, exp_cnt[k]);
            end
            n_checks++;
            if (bus_if.BUSY !== 1'(exp_busy[k])) begin
                n_fail++; $display("FAIL basic_busy ld_mid=%0d edge%0d: got %b want %0d", ld_mid, k, bus_if.BUSY, exp_busy[k]);
            end
            n_checks++;
            if (bus_if.DONE !== 1'(exp_done[k])) begin
                n_fail++; $display("FAIL basic_done ld_mid=%0d edge%0d: got %b want %0d", ld_mid, k, bus_if.DONE, exp_done[k]);
            end
        end
    endtask

    task automatic test_stall();
        int en[10]      = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        int exp_q[9]    = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        int exp_cnt[9]  = '{3, 2, 2, 2, 2, 1, 0, 0, 0};
        int exp_busy[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        int exp_done[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        bus_if.P  = 4'b1001;
        bus_if.LD = 1'b1;
        bus_if.EN = 1'(en[0]);
        for (int k = 0; k < 9; k++) begin
            tick();
            bus_if.LD = 1'b0;
            bus_if.EN = 1'(en[k+1]);
            n_checks++;
            if (bus_if.Q !== 1'(exp_q[k])) begin
                n_fail++; $display("FAIL stall_q edge%0d: got %b want %0d", k, bus_if.Q, exp_q[k]);
            end
            n_checks++;
            if (bus_if.CNT !== 2'(exp_cnt[k])) begin
                n_fail++; $display("FAIL stall_cnt edge%0d: got %0d want %0d", k, bus_if.CNT, exp_cnt[k]);
            end
            n_checks++;
            if (bus_if.BUSY !== 1'(exp_busy[k])) begin
                n_fail++; $display("FAIL stall_busy edge%0d: got %b want %0d", k, bus_if.BUSY, exp_busy[k]);
            end
            n_checks++;
            if (bus_if.DONE !== 1'(exp_done[k])) begin
                n_fail++; $display("FAIL stall_done edge%0d: got %b want %0d", k, bus_if.DONE, exp_done[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[11]    = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0};
        int exp_cnt[11]  = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 0};
        int exp_busy[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        int exp_done[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        int done_pulses  = 0;
        bus_if.P  = 4'b1011;
        bus_if.LD = 1'b1;
        bus_if.EN = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            bus_if.LD = (k == 4) ? 1'b1 : 1'b0;
            bus_if.P  = (k == 4) ? 4'b0101 : 4'b1011;
            if (bus_if.DONE === 1'b1) done_pulses++;
            n_checks++;
            if (bus_if.Q !== 1'(exp_q[k])) begin
                n_fail++; $display("FAIL b2b_q edge%0d: got %b want %0d", k, bus_if.Q, exp_q[k]);
            end
            n_checks++;
            if (bus_if.CNT !== 2'(exp_cnt[k])) begin
                n_fail++; $display("FAIL b2b_cnt edge%0d: got %0d want %0d", k, bus_if.CNT, exp_cnt[k]);
            end
            n_checks++;
            if (bus_if.BUSY !== 1'(exp_busy[k])) begin
                n_fail++; $display("FAIL b2b_busy edge%0d: got %b want %0d", k, bus_if.BUSY, exp_busy[k]);
            end
            n_checks++;
            if (bus_if.DONE !== 1'(exp_done[k])) begin
                n_fail++; $display("FAIL b2b_done edge%0d: got %b want %0d", k, bus_if.DONE, exp_done[k]);
            end
        end
        n_checks++;
        if (done_pulses != 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_pulses);
        end
    endtask

    task automatic test_reset_mid_word();
        int exp_q[6]    = '{1, 1, 1, 0, 0, 0};
        int exp_cnt[6]  = '{3, 2, 1, 0, 0, 0};
        int exp_busy[6] = '{1, 1, 1, 1, 0, 0};
        int exp_done[6] = '{0, 0, 0, 0, 1, 0};
        bus_if.P  = 4'b1011;
        bus_if.LD = 1'b1;
        bus_if.EN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus_if.LD = 1'b0;
        end
        n_checks++;
        if (bus_if.CNT !== 2'd1) begin
            n_fail++; $display("FAIL rst_mid_precnt: got %0d want 1", bus_if.CNT);
        end
        #2;
        R = 1'b1;
        #1;
        n_checks++;
        if (bus_if.Q !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_q: got %b want 0", bus_if.Q);
        end
        n_checks++;
        if (bus_if.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus_if.BUSY);
        end
        n_checks++;
        if (bus_if.CNT !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", bus_if.CNT);
        end
        #1;
        R = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus_if.DONE !== 1'b0 || bus_if.BUSY !== 1'b0 || bus_if.Q !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_quiet edge%0d: got done=%b busy=%b q=%b want 0 0 0", k, bus_if.DONE, bus_if.BUSY, bus_if.Q);
            end
        end
        bus_if.P  = 4'b1110;
        bus_if.LD = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            bus_if.LD = 1'b0;
            n_checks++;
            if (bus_if.Q !== 1'(exp_q[k])) begin
                n_fail++; $display("FAIL rst_reload_q edge%0d: got %b want %0d", k, bus_if.Q, exp_q[k]);
            end
            n_checks++;
            if (bus_if.CNT !== 2'(exp_cnt[k])) begin
                n_fail++; $display("FAIL rst_reload_cnt edge%0d: got %0d want %0d", k, bus_if.CNT, exp_cnt[k]);
            end
            n_checks++;
            if (bus_if.BUSY !== 1'(exp_busy[k])) begin
                n_fail++; $display("FAIL rst_reload_busy edge%0d: got %b want %0d", k, bus_if.BUSY, exp_busy[k]);
            end
            n_checks++;
            if (bus_if.DONE !== 1'(exp_done[k])) begin
                n_fail++; $display("FAIL rst_reload_done edge%0d: got %b want %0d", k, bus_if.DONE, exp_done[k]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        R         = 1'b1;
        bus_if.P  = 4'b0000;
        bus_if.LD = 1'b0;
        bus_if.EN = 1'b0;
        test_reset();
        test_basic_word(1'b0);
        test_basic_word(1'b1);
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register: the transmit end of the team's serial-in, parallel-out shift register chain.
- Captures a WIDTH-bit word on a load strobe and drives it out MSB-first on a single serial line, one bit per enabled rising clock edge.
- Reports BUSY/DONE so a controller can pace back-to-back words.
- Feeds the D input of the team's shift-register receivers, which share the same clock C.

Parameters:
WIDTH, 4, word length in bits; legal range 1..32
CW, max(1,clog2(WIDTH)), bit-counter width (derived, not overridable)

Ports:
C  input  1  clock; all state updates on rising edge
R  input  1  reset, asynchronous, active-high
P  input  WIDTH  parallel data word, sampled only on an accepted load
LD  input  1  load strobe
EN  input  1  shift enable; paces serial output (stall when 0)
Q  output  1  serial data out, MSB first; driven directly from shift-register MSB
BUSY  output  1  word in flight, LD ignored
DONE  output  1  one-cycle pulse after last bit has been held for its cycle
CNT  output  CW  bits remaining after the one currently on Q

Behaviour:
- Reset (R=1, any time, asynchronous): sreg=0, Q=0, CNT=0, BUSY=0, DONE=0, state=IDLE. This applies mid-word too: the partial word is discarded and no DONE is issued. On the first edge after R falls, the block is in IDLE.
- States are IDLE, SHIFT and FIN.
- IDLE:
  - LD=1 at an edge -> sreg<=P, CNT<=WIDTH-1, BUSY<=1, state SHIFT. Q shows P[WIDTH-1] in the cycle after the load edge (0-cycle capture latency, 1-edge output latency).
  - LD=0 -> hold; Q=0.
- SHIFT:
  - EN=1 and CNT>0 -> sreg<={sreg[WIDTH-2:0],0}, CNT<=CNT-1.
  - EN=1 and CNT==0 -> sreg<=0, BUSY<=0, DONE<=1, state FIN.
  - EN=0 -> hold everything; Q is stable for the whole stall.
  - LD is ignored throughout SHIFT; P is not sampled.
- FIN (DONE=1 for exactly this cycle):
  - LD=1 -> load exactly as from IDLE (back-to-back word; one-cycle gap with Q=0).
  - LD=0 -> IDLE. DONE<=0 in both cases.
- With EN held at 1, each bit is on Q for exactly one cycle. A word occupies WIDTH cycles plus 1 FIN cycle.
- WIDTH=1: CNT is always 0. The load edge is followed by one bit cycle, then FIN.
- EN during IDLE or FIN has no effect. Simultaneous LD and EN in FIN: the load wins.
- Q changes only just after a rising C. A receiver clocked on the same C samples bit k on edge k+1 after the load edge.

Test Plan:
- Reset then idle: R pulse, LD=0, 5 edges -> Q=0, BUSY=0, DONE=0, CNT=0 throughout.
- Basic word, WIDTH=4, P=4'b1011, LD at edge0, EN=1 -> Q=1,0,1,1 after edges 0..3, CNT=3,2,1,0, BUSY=1. After edge4: Q=0, DONE=1, BUSY=0. After edge5: DONE=0.
- Stall: P=4'b1001, EN=0 for 3 edges after edge1 -> Q held at 0 and CNT held at 2 for those edges. The sequence then resumes 0,1 and DONE comes 3 edges later than the unstalled case.
- LD ignored while busy: during the basic word, pulse LD with P=4'b0110 at edge2 -> output stream is unchanged (1,0,1,1).
- Back-to-back: LD=1 in the FIN cycle with P=4'b0101 -> Q=0 (gap), then 0,1,0,1. DONE pulses once per word.
- Reset mid-word: assert R asynchronously between edge2 and edge3 of the basic word -> Q, BUSY, CNT drop to 0 immediately and no DONE follows. A subsequent LD with P=4'b1110 transmits 1,1,1,0 correctly.
